riscv_multicycle_ctrl: RTL and testbench
========================================

RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/instruction width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max wait cycles for memory ack before error.
REQ-003 SHALL have port clk input 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst input 1, reset; synchronous, active-high.
REQ-005 SHALL have port imem_req output 1, instruction fetch request.
REQ-006 SHALL have port imem_ack input 1, fetch complete; imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata input XLEN, fetched instruction word.
REQ-008 SHALL have port instruction output XLEN, latched instruction to datapath.
REQ-009 SHALL have port dmem_req output 1, data memory request.
REQ-010 SHALL have port dmem_we output 1, 1 = store, 0 = load; valid while dmem_req.
REQ-011 SHALL have port dmem_ack input 1, data access complete.
REQ-012 SHALL have port Zero input 1, ALU zero flag from datapath.
REQ-013 SHALL have ports PCSrc, ALUSrc, RegWrite, MemtoReg output 1 each, datapath controls.
REQ-014 SHALL have port ALUCtrl output 4, ALU operation select.
REQ-015 SHALL have port pc_en output 1, PC update enable for datapath.
REQ-016 SHALL have ports error output 1 (sticky fault) and instret output 32 (retired instruction count).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, EXEC, MEM, COMMIT, ERROR.
REQ-018 SHALL go IDLE->FETCH unconditionally one cycle after rst deasserts.
REQ-019 SHALL assert imem_req throughout FETCH; on imem_ack, latch imem_rdata into instruction and go to EXEC.
REQ-020 SHALL decode in EXEC; legal load (opcode 0000011, funct3 010) or store (0100011, funct3 010) goes to MEM; other legal ops go to COMMIT; any other encoding goes to ERROR.
REQ-021 SHALL treat as legal: R-type 0110011 with ADD/SUB/AND/OR/XOR/SLT; I-type 0010011 with ADDI/ANDI/ORI/XORI/SLTI; BRANCH 1100011 funct3 000 (BEQ) only.
REQ-022 SHALL encode ALUCtrl as AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1101; load/store use ADD, BEQ uses SUB.
REQ-023 SHALL select R-type SUB only for funct7 0100000 with funct3 000; funct7 other than 0000000/0100000 in R-type is illegal.
REQ-024 SHALL drive ALUSrc = 1 for I-type/load/store, MemtoReg = 1 for load only; both plus ALUCtrl held stable from EXEC through COMMIT.
REQ-025 SHALL assert dmem_req throughout MEM with dmem_we = 1 for store; on dmem_ack go to COMMIT.
REQ-026 SHALL in COMMIT, for exactly one cycle: pc_en = 1; RegWrite = 1 for R/I/load; PCSrc = Zero for BEQ, else 0; instret += 1 (wraps 2^32-1 -> 0); then go to FETCH.
REQ-027 SHALL keep RegWrite, pc_en, PCSrc at 0 in every state except COMMIT.
REQ-028 SHALL drop req the cycle after ack is sampled; ack while req is low SHALL be ignored.
REQ-029 SHALL count consecutive wait cycles in FETCH/MEM; counter clears on state entry; reaching TIMEOUT without ack goes to ERROR; ack in the same cycle wins.
REQ-030 SHALL hold ERROR with error = 1, all reqs and strobes 0, until rst.

Reset
REQ-031 SHALL during rst force state IDLE, all outputs 0, instruction 0, instret 0, error 0, wait counter 0.
REQ-032 SHALL abort any in-flight fetch/MEM access on rst mid-operation with no COMMIT and no instret change.

Structure
REQ-033 SHALL place opcode constants, ALUCtrl encodings and the state enum in the shared riscv_core_p package.
REQ-034 SHALL implement decode as one combinational sub-module riscv_ctrl_decode (instruction in; ALUCtrl, ALUSrc, MemtoReg, RegWrite, is_mem, is_store, is_branch, illegal out).

Verification
REQ-035 SHALL test add x3,x1,x2 (0x002081B3) with ack after 2 cycles -> ALUCtrl 0010, one-cycle RegWrite/pc_en in COMMIT, instret 0->1.
REQ-036 SHALL test lw (0x0000A183) with dmem_ack after 3 cycles -> dmem_req 3 cycles, dmem_we 0, MemtoReg 1, RegWrite in COMMIT.
REQ-037 SHALL test beq (0x00208463) with Zero 1 then Zero 0 -> PCSrc 1 then 0 in COMMIT, RegWrite 0 both times.
REQ-038 SHALL test imem_ack never asserted -> ERROR after 16 wait cycles, error stays 1 until rst, then IDLE->FETCH.
REQ-039 SHALL test illegal word 0xFFFFFFFF -> ERROR from EXEC, no pc_en, instret unchanged.
REQ-040 SHALL test rst asserted mid-MEM for sw (0x0020A223) -> dmem_req 0 next cycle, no COMMIT, instret unchanged.

Source files
------------

// File: rtl/riscv_core_p.sv
// Shared opcode/funct constants, ALU operation codes and controller state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_core_p;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    COMMIT = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Maps the funct3 shared by R-type and I-type ALU ops to {supported, ALU code}.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return {1'b1, ALU_ADD};
      F3_SLT:  return {1'b1, ALU_SLT};
      F3_XOR:  return {1'b1, ALU_XOR};
      F3_OR:   return {1'b1, ALU_OR};
      F3_AND:  return {1'b1, ALU_AND};
      default: return {1'b0, ALU_AND};
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Instruction decoder: datapath controls and legality for the supported RV32 subset.
// Latency: purely combinational.
// Backpressure: none; outputs follow the instruction word directly.
module riscv_ctrl_decode
  import riscv_core_p::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [3:0]      ALUCtrl,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            is_mem,
  output logic            is_store,
  output logic            is_branch,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f3_ok;
  logic [3:0] f3_alu;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign {f3_ok, f3_alu} = alu_from_f3(funct3);
  // Register and immediate fields belong to the datapath, not to control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Decode opcode/funct fields; anything unrecognised is flagged illegal with all controls low.
  always_comb begin
    ALUCtrl   = ALU_AND;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE && f3_ok) begin
          ALUCtrl  = f3_alu;
          RegWrite = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          ALUCtrl  = ALU_SUB;
          RegWrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ITYPE: begin
        if (f3_ok) begin
          ALUCtrl  = f3_alu;
          ALUSrc   = 1'b1;
          RegWrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == F3_W) begin
          ALUCtrl  = ALU_ADD;
          ALUSrc   = 1'b1;
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          is_mem   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_W) begin
          ALUCtrl  = ALU_ADD;
          ALUSrc   = 1'b1;
          is_mem   = 1'b1;
          is_store = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          ALUCtrl   = ALU_SUB;
          is_branch = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32 subset controller: fetch, decode/execute, optional data access, commit.
// Latency: 1 IDLE cycle after reset; per instruction FETCH(>=1) + EXEC(1) + MEM(>=1, ld/st) + COMMIT(1).
// Backpressure: memory req is held until ack; no ack within TIMEOUT cycles parks the FSM in ERROR.
module riscv_multicycle_ctrl
  import riscv_core_p::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            Zero,
  output logic            PCSrc,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            MemtoReg,
  output logic [3:0]      ALUCtrl,
  output logic            pc_en,
  output logic            error,
  output logic [31:0]     instret
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  logic [3:0]    dec_alu;
  logic          dec_alusrc;
  logic          dec_memtoreg;
  logic          dec_regwrite;
  logic          dec_is_mem;
  logic          dec_is_store;
  logic          dec_is_branch;
  logic          dec_illegal;

  riscv_ctrl_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr     (instruction),
    .ALUCtrl   (dec_alu),
    .ALUSrc    (dec_alusrc),
    .MemtoReg  (dec_memtoreg),
    .RegWrite  (dec_regwrite),
    .is_mem    (dec_is_mem),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  // This is the last permitted wait cycle; an ack arriving now still wins.
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   next_state = FETCH;
      FETCH:  if (imem_ack) next_state = EXEC;
              else if (timed_out) next_state = ERROR;
      EXEC:   if (dec_illegal) next_state = ERROR;
              else if (dec_is_mem) next_state = MEM;
              else next_state = COMMIT;
      MEM:    if (dmem_ack) next_state = COMMIT;
              else if (timed_out) next_state = ERROR;
      COMMIT: next_state = FETCH;
      ERROR:  next_state = ERROR;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from state; everything is held low while rst is asserted.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUCtrl  = ALU_AND;
    pc_en    = 1'b0;
    error    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: imem_req = 1'b1;
        EXEC: begin
          ALUCtrl  = dec_alu;
          ALUSrc   = dec_alusrc;
          MemtoReg = dec_memtoreg;
        end
        MEM: begin
          ALUCtrl  = dec_alu;
          ALUSrc   = dec_alusrc;
          MemtoReg = dec_memtoreg;
          dmem_req = 1'b1;
          dmem_we  = dec_is_store;
        end
        COMMIT: begin
          ALUCtrl  = dec_alu;
          ALUSrc   = dec_alusrc;
          MemtoReg = dec_memtoreg;
          pc_en    = 1'b1;
          RegWrite = dec_regwrite;
          PCSrc    = dec_is_branch & Zero;
        end
        ERROR: error = 1'b1;
        default: ;
      endcase
    end
  end

  // Capture the fetched word on the accepted handshake only.
  always_ff @(posedge clk) begin
    if (rst)                          instruction <= '0;
    else if (state == FETCH && imem_ack) instruction <= imem_rdata;
  end

  // Wait-cycle counter: restarts on every state change, runs while waiting on memory.
  always_ff @(posedge clk) begin
    if (rst)                                  wait_cnt <= '0;
    else if (next_state != state)             wait_cnt <= '0;
    else if (state == FETCH || state == MEM)  wait_cnt <= wait_cnt + 1'b1;
  end

  // Retired-instruction counter, one increment per COMMIT, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst)                  instret <= '0;
    else if (state == COMMIT) instret <= instret + 32'd1;
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for the multicycle controller: a vector table driven through full instruction
// sequences, plus hand-written timeout, ack-ignore and reset-abort sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        Zero;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemtoReg;
  logic [3:0]  ALUCtrl;
  logic        pc_en;
  logic        error;
  logic [31:0] instret;

  riscv_multicycle_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .Zero(Zero), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUCtrl(ALUCtrl), .pc_en(pc_en), .error(error), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  alu;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        is_mem;
    logic        is_store;
    logic        pcsrc;
    logic        illegal;
  } vec_t;

  localparam int NV = 21;
  vec_t        vecs [NV];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_ir = 32'd0;

  function automatic vec_t mk(logic [31:0] i, logic z, logic [3:0] a, logic s, logic m2r,
                              logic rw, logic mem, logic st, logic pcs, logic ill);
    vec_t v;
    v.instr = i; v.zero = z; v.alu = a; v.alusrc = s; v.memtoreg = m2r;
    v.regwrite = rw; v.is_mem = mem; v.is_store = st; v.pcsrc = pcs; v.illegal = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; Zero = 1'b0;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", {22'd0, imem_req, dmem_req, dmem_we, PCSrc, ALUSrc, RegWrite, MemtoReg,
                        pc_en, error, 1'b0}, 32'd0);
    chk("rst_aluctrl", {28'd0, ALUCtrl}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instret", instret, 32'd0);
    exp_ir = 32'd0;
    rst = 1'b0;
    #1;
    chk("idle_no_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("idle_to_fetch", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic wait_fetch();
    int k = 0;
    while (imem_req !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_reached", {31'd0, imem_req}, 32'd1);
  endtask

  // Holds req unanswered for 'waits' cycles, then acks; ends in EXEC.
  task automatic fetch(input logic [31:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("fetch_wait_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
    end
    chk("fetch_ack_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF;
    chk("fetch_req_drop", {31'd0, imem_req}, 32'd0);
    chk("fetch_latch", instruction, w);
  endtask

  task automatic run_vec(input vec_t v, input int fwaits);
    Zero = v.zero;
    wait_fetch();
    fetch(v.instr, fwaits);
    chk("exec_aluctrl", {28'd0, ALUCtrl}, {28'd0, v.alu});
    chk("exec_alusrc_m2r", {30'd0, ALUSrc, MemtoReg}, {30'd0, v.alusrc, v.memtoreg});
    chk("exec_strobes_low", {29'd0, RegWrite, pc_en, PCSrc}, 32'd0);
    @(negedge clk);
    if (v.illegal) begin
      chk("illegal_error", {31'd0, error}, 32'd1);
      chk("illegal_no_pc_en", {31'd0, pc_en}, 32'd0);
      chk("illegal_instret", instret, exp_ir);
      @(negedge clk);
      chk("illegal_error_held", {30'd0, error, pc_en}, 32'd2);
      do_reset();
    end else begin
      if (v.is_mem) begin
        for (int k = 0; k < 3; k++) begin
          chk("mem_req", {31'd0, dmem_req}, 32'd1);
          chk("mem_we", {31'd0, dmem_we}, {31'd0, v.is_store});
          chk("mem_ctrl_hold", {26'd0, ALUCtrl, ALUSrc, MemtoReg},
              {26'd0, v.alu, v.alusrc, v.memtoreg});
          chk("mem_strobes_low", {29'd0, RegWrite, pc_en, PCSrc}, 32'd0);
          dmem_ack = (k == 2);
          @(negedge clk);
        end
        dmem_ack = 1'b0;
      end
      chk("commit_pc_en", {31'd0, pc_en}, 32'd1);
      chk("commit_regwrite", {31'd0, RegWrite}, {31'd0, v.regwrite});
      chk("commit_pcsrc", {31'd0, PCSrc}, {31'd0, v.pcsrc});
      chk("commit_ctrl_hold", {26'd0, ALUCtrl, ALUSrc, MemtoReg},
          {26'd0, v.alu, v.alusrc, v.memtoreg});
      chk("commit_no_dmem", {31'd0, dmem_req}, 32'd0);
      @(negedge clk);
      exp_ir = exp_ir + 32'd1;
      chk("instret_step", instret, exp_ir);
      chk("post_commit_strobes", {29'd0, RegWrite, pc_en, PCSrc}, 32'd0);
      chk("post_commit_fetch", {31'd0, imem_req}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           instr         z  alu     src m2r rw mem st pcs ill
    vecs[0]  = mk(32'h002081B3, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 0); // add
    vecs[1]  = mk(32'h402081B3, 1, 4'b0110, 0, 0, 1, 0, 0, 0, 0); // sub, Zero ignored
    vecs[2]  = mk(32'h0020F1B3, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0); // and
    vecs[3]  = mk(32'h0020E1B3, 0, 4'b0001, 0, 0, 1, 0, 0, 0, 0); // or
    vecs[4]  = mk(32'h0020C1B3, 0, 4'b1101, 0, 0, 1, 0, 0, 0, 0); // xor
    vecs[5]  = mk(32'h0020A1B3, 0, 4'b0111, 0, 0, 1, 0, 0, 0, 0); // slt
    vecs[6]  = mk(32'h00508193, 0, 4'b0010, 1, 0, 1, 0, 0, 0, 0); // addi
    vecs[7]  = mk(32'h0050F193, 0, 4'b0000, 1, 0, 1, 0, 0, 0, 0); // andi
    vecs[8]  = mk(32'h0050E193, 0, 4'b0001, 1, 0, 1, 0, 0, 0, 0); // ori
    vecs[9]  = mk(32'h0050C193, 0, 4'b1101, 1, 0, 1, 0, 0, 0, 0); // xori
    vecs[10] = mk(32'h0050A193, 0, 4'b0111, 1, 0, 1, 0, 0, 0, 0); // slti
    vecs[11] = mk(32'h0000A183, 0, 4'b0010, 1, 1, 1, 1, 0, 0, 0); // lw
    vecs[12] = mk(32'h0020A223, 0, 4'b0010, 1, 0, 0, 1, 1, 0, 0); // sw
    vecs[13] = mk(32'h00208463, 1, 4'b0110, 0, 0, 0, 0, 0, 1, 0); // beq taken
    vecs[14] = mk(32'h00208463, 0, 4'b0110, 0, 0, 0, 0, 0, 0, 0); // beq not taken
    vecs[15] = mk(32'hFFFFFFFF, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1); // all ones
    vecs[16] = mk(32'h022081B3, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1); // R-type funct7 0000001
    vecs[17] = mk(32'h4020F1B3, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1); // funct7 0100000 with funct3 111
    vecs[18] = mk(32'h00509193, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1); // slli (unsupported)
    vecs[19] = mk(32'h00008183, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1); // lb (unsupported width)
    vecs[20] = mk(32'h00209463, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1); // bne (unsupported)

    do_reset();
    for (int i = 0; i < NV; i++) run_vec(vecs[i], 2);

    // Ack on the last permitted wait cycle still completes the fetch.
    run_vec(vecs[0], 15);

    // Ack presented while no request is outstanding must not be taken as a fetch.
    wait_fetch();
    fetch(32'h002081B3, 0);
    @(negedge clk);                          // COMMIT
    imem_ack = 1'b1; imem_rdata = 32'hFFFFFFFF;
    @(negedge clk);                          // FETCH, stray ack already sampled in COMMIT
    imem_ack = 1'b0;
    chk("stray_ack_instr", instruction, 32'h002081B3);
    chk("stray_ack_still_fetch", {31'd0, imem_req}, 32'd1);
    exp_ir = exp_ir + 32'd1;
    chk("stray_ack_instret", instret, exp_ir);

    // Fetch timeout: 16 unanswered cycles, then sticky ERROR that ignores acks until reset.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("timeout_wait", {30'd0, imem_req, error}, 32'd2);
      @(negedge clk);
    end
    chk("timeout_error", {30'd0, imem_req, error}, 32'd1);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("error_sticky", {27'd0, error, imem_req, dmem_req, pc_en, RegWrite}, 32'h10);
      chk("error_instret", instret, 32'd0);
    end
    do_reset();

    // Data-side timeout on a load that never gets dmem_ack.
    fetch(32'h0000A183, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("mem_timeout_wait", {30'd0, dmem_req, error}, 32'd2);
      @(negedge clk);
    end
    chk("mem_timeout_error", {30'd0, dmem_req, error}, 32'd1);

    // Reset in the middle of a store access aborts it without committing.
    do_reset();
    fetch(32'h0020A223, 1);
    @(negedge clk);
    chk("sw_mem_req", {30'd0, dmem_req, dmem_we}, 32'd3);
    @(negedge clk);
    chk("sw_mem_req_2", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_mem_no_commit", {30'd0, pc_en, RegWrite}, 32'd0);
    chk("rst_mid_mem_instret", instret, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_idle", {29'd0, imem_req, dmem_req, pc_en}, 32'd0);
    @(negedge clk);
    chk("rst_mid_mem_fetch", {29'd0, imem_req, dmem_req, pc_en}, 32'd4);
    chk("rst_mid_mem_instret_2", instret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
